// File: rtl/jtag_pkg.sv
// Shared types and constants for the parametrised JTAG TAP: state encoding,
// instruction codes and the data-register selector.
package jtag_pkg;

  // The 16 TAP controller states; the numeric codes appear on tap_state.
  typedef enum logic [3:0] {
    ST_TLR    = 4'd0,
    ST_RTI    = 4'd1,
    ST_SEL_DR = 4'd2,
    ST_CAP_DR = 4'd3,
    ST_SH_DR  = 4'd4,
    ST_EX1_DR = 4'd5,
    ST_PA_DR  = 4'd6,
    ST_EX2_DR = 4'd7,
    ST_UPD_DR = 4'd8,
    ST_SEL_IR = 4'd9,
    ST_CAP_IR = 4'd10,
    ST_SH_IR  = 4'd11,
    ST_EX1_IR = 4'd12,
    ST_PA_IR  = 4'd13,
    ST_EX2_IR = 4'd14,
    ST_UPD_IR = 4'd15
  } tap_state_e;

  // Which data register sits between tdi and tdo for the active instruction.
  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_BSR    = 2'd2,
    DR_USER   = 2'd3
  } dr_sel_e;

  localparam int unsigned INSTR_EXTEST = 32'd0;
  localparam int unsigned INSTR_IDCODE = 32'd1;
  localparam int unsigned INSTR_SAMPLE = 32'd2;
  localparam int unsigned INSTR_USER   = 32'd3;

  // All-ones BYPASS opcode for an IR of the given width (up to 32 bits).
  function automatic logic [31:0] instr_bypass(input int unsigned ir_w);
    logic [31:0] ones;
    ones = {32{1'b1}};
    return ones >> (32 - ir_w);
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller sequencer. Walks the state graph on
// tms and decodes one-hot strobes for the states the datapath acts on.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tms,
  output logic [3:0] state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       tlr
);

  tap_state_e state_q;
  tap_state_e state_d;

  // State register; TRST drops the controller straight into Test-Logic-Reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state graph; each state branches on tms exactly as the standard draws it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:    state_d = tms ? ST_TLR    : ST_RTI;
      ST_RTI:    state_d = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_d = tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_d = tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_d = tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_d = tms ? ST_UPD_DR : ST_PA_DR;
      ST_PA_DR:  state_d = tms ? ST_EX2_DR : ST_PA_DR;
      ST_EX2_DR: state_d = tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_d = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_d = tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_d = tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_d = tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_d = tms ? ST_UPD_IR : ST_PA_IR;
      ST_PA_IR:  state_d = tms ? ST_EX2_IR : ST_PA_IR;
      ST_EX2_IR: state_d = tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_d = tms ? ST_SEL_DR : ST_RTI;
      default:   state_d = ST_TLR;
    endcase
  end

  // Action strobes decoded from the current state; the datapath acts on the edge leaving it.
  always_comb begin
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    tlr        = 1'b0;
    case (state_q)
      ST_CAP_DR: capture_dr = 1'b1;
      ST_SH_DR:  shift_dr   = 1'b1;
      ST_UPD_DR: update_dr  = 1'b1;
      ST_CAP_IR: capture_ir = 1'b1;
      ST_SH_IR:  shift_ir   = 1'b1;
      ST_UPD_IR: update_ir  = 1'b1;
      ST_TLR:    tlr        = 1'b1;
      default:   ;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised JTAG TAP: instruction register, IDCODE / boundary-scan /
// user / bypass data registers, instruction decode and the registered TDO.
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_W       = 4,
  parameter int unsigned          ID_W       = 32,
  parameter logic [ID_W-1:0]      IDCODE_VAL = ID_W'(32'h1000_0A5B),
  parameter int unsigned          BSR_W      = 8,
  parameter int unsigned          USER_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tdi,
  input  logic              tms,
  output logic              tdo,
  output logic              tdo_en,
  output logic [3:0]        tap_state,
  output logic [IR_W-1:0]   ir_q,
  input  logic [BSR_W-1:0]  bsr_pin_in,
  output logic [BSR_W-1:0]  bsr_pin_out,
  output logic              bsr_extest,
  input  logic [USER_W-1:0] user_cap,
  output logic [USER_W-1:0] user_q,
  output logic              user_upd
);

  // Bad configurations are rejected while elaborating rather than at run time.
  if (IR_W < 2) begin : g_ir_w_chk
    $error("jtag_tap_param: IR_W must be at least 2");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_chk
    $error("jtag_tap_param: IDCODE_VAL bit 0 must be 1");
  end

  localparam logic [IR_W-1:0] IR_EXTEST = IR_W'(INSTR_EXTEST);
  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(INSTR_IDCODE);
  localparam logic [IR_W-1:0] IR_SAMPLE = IR_W'(INSTR_SAMPLE);
  localparam logic [IR_W-1:0] IR_USER   = IR_W'(INSTR_USER);
  localparam logic [IR_W-1:0] IR_BYPASS = IR_W'(instr_bypass(IR_W));
  localparam logic [IR_W-1:0] IR_CAPT   = IR_W'(2'b01);

  logic capture_dr_s, shift_dr_s, update_dr_s;
  logic capture_ir_s, shift_ir_s, update_ir_s;
  logic tlr_s;
  dr_sel_e dr_sel_s;

  logic [IR_W-1:0]   instr_q,    instr_d;
  logic [IR_W-1:0]   ir_sh_q,    ir_sh_d;
  logic [ID_W-1:0]   id_sh_q,    id_sh_d;
  logic [BSR_W-1:0]  bsr_sh_q,   bsr_sh_d;
  logic [USER_W-1:0] user_sh_q,  user_sh_d;
  logic              byp_q,      byp_d;
  logic [BSR_W-1:0]  bsr_out_q,  bsr_out_d;
  logic [USER_W-1:0] user_lat_q, user_lat_d;
  logic              user_upd_q, user_upd_d;
  logic              tdo_q,      tdo_d;
  logic              tdo_en_q,   tdo_en_d;

  jtag_tap_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .tms        (tms),
    .state      (tap_state),
    .capture_dr (capture_dr_s),
    .shift_dr   (shift_dr_s),
    .update_dr  (update_dr_s),
    .capture_ir (capture_ir_s),
    .shift_ir   (shift_ir_s),
    .update_ir  (update_ir_s),
    .tlr        (tlr_s)
  );

  // Instruction decode; unrecognised opcodes fall back to the bypass bit.
  always_comb begin
    dr_sel_s = DR_BYPASS;
    case (instr_q)
      IR_EXTEST: dr_sel_s = DR_BSR;
      IR_SAMPLE: dr_sel_s = DR_BSR;
      IR_IDCODE: dr_sel_s = DR_IDCODE;
      IR_USER:   dr_sel_s = DR_USER;
      IR_BYPASS: dr_sel_s = DR_BYPASS;
      default:   dr_sel_s = DR_BYPASS;
    endcase
  end

  // Capture/shift/update datapath; anything not touched by the current state holds.
  always_comb begin
    instr_d    = instr_q;
    ir_sh_d    = ir_sh_q;
    id_sh_d    = id_sh_q;
    bsr_sh_d   = bsr_sh_q;
    user_sh_d  = user_sh_q;
    byp_d      = byp_q;
    bsr_out_d  = bsr_out_q;
    user_lat_d = user_lat_q;
    user_upd_d = 1'b0;
    tdo_d      = tdo_q;
    tdo_en_d   = shift_ir_s | shift_dr_s;

    if (tlr_s) begin
      instr_d = IR_IDCODE;
    end else if (update_ir_s) begin
      instr_d = ir_sh_q;
    end else begin
      instr_d = instr_q;
    end

    if (capture_ir_s) begin
      ir_sh_d = IR_CAPT;
    end else if (shift_ir_s) begin
      ir_sh_d = {tdi, ir_sh_q[IR_W-1:1]};
      tdo_d   = ir_sh_q[0];
    end else begin
      ir_sh_d = ir_sh_q;
    end

    if (capture_dr_s) begin
      case (dr_sel_s)
        DR_IDCODE: id_sh_d   = IDCODE_VAL;
        DR_BSR:    bsr_sh_d  = bsr_pin_in;
        DR_USER:   user_sh_d = user_cap;
        DR_BYPASS: byp_d     = 1'b0;
        default:   byp_d     = 1'b0;
      endcase
    end else if (shift_dr_s) begin
      case (dr_sel_s)
        DR_IDCODE: begin
          id_sh_d = {tdi, id_sh_q[ID_W-1:1]};
          tdo_d   = id_sh_q[0];
        end
        DR_BSR: begin
          bsr_sh_d = {tdi, bsr_sh_q[BSR_W-1:1]};
          tdo_d    = bsr_sh_q[0];
        end
        DR_USER: begin
          user_sh_d = {tdi, user_sh_q[USER_W-1:1]};
          tdo_d     = user_sh_q[0];
        end
        DR_BYPASS: begin
          byp_d = tdi;
          tdo_d = byp_q;
        end
        default: begin
          byp_d = tdi;
          tdo_d = byp_q;
        end
      endcase
    end else if (update_dr_s) begin
      case (dr_sel_s)
        DR_BSR:  bsr_out_d = bsr_sh_q;
        DR_USER: begin
          user_lat_d = user_sh_q;
          user_upd_d = 1'b1;
        end
        default: ;
      endcase
    end else begin
      byp_d = byp_q;
    end
  end

  // All TAP-side storage; TRST returns every register to its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= IR_IDCODE;
      ir_sh_q    <= '0;
      id_sh_q    <= '0;
      bsr_sh_q   <= '0;
      user_sh_q  <= '0;
      byp_q      <= 1'b0;
      bsr_out_q  <= '0;
      user_lat_q <= '0;
      user_upd_q <= 1'b0;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      ir_sh_q    <= ir_sh_d;
      id_sh_q    <= id_sh_d;
      bsr_sh_q   <= bsr_sh_d;
      user_sh_q  <= user_sh_d;
      byp_q      <= byp_d;
      bsr_out_q  <= bsr_out_d;
      user_lat_q <= user_lat_d;
      user_upd_q <= user_upd_d;
      tdo_q      <= tdo_d;
      tdo_en_q   <= tdo_en_d;
    end
  end

  assign ir_q        = instr_q;
  assign bsr_extest  = (instr_q == IR_EXTEST);
  assign bsr_pin_out = bsr_out_q;
  assign user_q      = user_lat_q;
  assign user_upd    = user_upd_q;
  assign tdo         = tdo_q;
  assign tdo_en      = tdo_en_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param: a table of IR/DR scan vectors plus
// hand-written sequences for pause/resume, TLR entry and mid-scan reset.
module tb_jtag_tap_param;

  logic        clk;
  logic        rst_n;
  logic        tdi;
  logic        tms;
  logic        tdo;
  logic        tdo_en;
  logic [3:0]  tap_state;
  logic [3:0]  ir_q;
  logic [7:0]  bsr_pin_in;
  logic [7:0]  bsr_pin_out;
  logic        bsr_extest;
  logic [15:0] user_cap;
  logic [15:0] user_q;
  logic        user_upd;

  int n_checks;
  int n_errors;

  jtag_tap_param dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tdi         (tdi),
    .tms         (tms),
    .tdo         (tdo),
    .tdo_en      (tdo_en),
    .tap_state   (tap_state),
    .ir_q        (ir_q),
    .bsr_pin_in  (bsr_pin_in),
    .bsr_pin_out (bsr_pin_out),
    .bsr_extest  (bsr_extest),
    .user_cap    (user_cap),
    .user_q      (user_q),
    .user_upd    (user_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One TCK: drive tms/tdi, take the rising edge, settle 1 ns past it.
  task automatic tck(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge clk);
    #1;
  endtask

  // IR scan from RTI back to RTI; returns the bits seen on tdo.
  task automatic scan_ir(input logic [3:0] val, output logic [3:0] out);
    out = 4'h0;
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tck(i == 3, val[i]);
      out[i] = tdo;
    end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  // DR scan of n bits from RTI back to RTI; returns the bits seen on tdo.
  task automatic scan_dr(input logic [31:0] val, input int n, output logic [31:0] out);
    out = 32'h0;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tck(i == n - 1, val[i]);
      out[i] = tdo;
    end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  typedef struct {
    logic [3:0]  ir;
    logic [7:0]  pin_in;
    logic [15:0] ucap;
    logic [31:0] dr_in;
    int          n;
    logic [31:0] exp_out;
    logic        exp_extest;
    logic [7:0]  exp_pin;
    logic [15:0] exp_uq;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [3:0]  ir_out;
    logic [31:0] dr_out;
    logic [31:0] idv;

    n_checks = 0;
    n_errors = 0;
    idv      = 32'h1000_0A5B;

    // ir, pin_in, user_cap, dr_in, n, expected tdo, extest, pin_out, user_q
    vecs[0] = '{4'hF, 8'h00, 16'h0000, 32'h0000_000D, 4,  32'h0000_000A, 1'b0, 8'h00, 16'h0000};
    vecs[1] = '{4'h7, 8'h00, 16'h0000, 32'h0000_0013, 5,  32'h0000_0006, 1'b0, 8'h00, 16'h0000};
    vecs[2] = '{4'h0, 8'h3C, 16'h0000, 32'h0000_00A5, 8,  32'h0000_003C, 1'b1, 8'hA5, 16'h0000};
    vecs[3] = '{4'h2, 8'h5A, 16'h0000, 32'h0000_000F, 8,  32'h0000_005A, 1'b0, 8'h0F, 16'h0000};
    vecs[4] = '{4'h1, 8'hFF, 16'h0000, 32'h0000_0000, 32, 32'h1000_0A5B, 1'b0, 8'h0F, 16'h0000};
    vecs[5] = '{4'h3, 8'h00, 16'h1234, 32'h0000_CAFE, 16, 32'h0000_1234, 1'b0, 8'h0F, 16'hCAFE};
    vecs[6] = '{4'hE, 8'h00, 16'h0000, 32'h0000_0003, 2,  32'h0000_0002, 1'b0, 8'h0F, 16'hCAFE};

    rst_n      = 1'b0;
    tms        = 1'b1;
    tdi        = 1'b0;
    bsr_pin_in = 8'h00;
    user_cap   = 16'h0000;
    #12;
    chk("reset tap_state", 32'(tap_state), 32'd0);
    chk("reset ir_q", 32'(ir_q), 32'd1);
    chk("reset tdo_en", 32'(tdo_en), 32'd0);
    chk("reset tdo", 32'(tdo), 32'd0);
    chk("reset bsr_pin_out", 32'(bsr_pin_out), 32'd0);
    chk("reset user_q", 32'(user_q), 32'd0);
    chk("reset bsr_extest", 32'(bsr_extest), 32'd0);
    chk("reset user_upd", 32'(user_upd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // IDCODE read straight out of reset.
    tck(1'b0, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    chk("reach CAP_DR", 32'(tap_state), 32'd3);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      tck(i == 31, 1'b0);
      chk($sformatf("idcode bit %0d", i), 32'(tdo), 32'(idv[i]));
      chk($sformatf("idcode tdo_en %0d", i), 32'(tdo_en), 32'd1);
    end
    tck(1'b1, 1'b0);
    chk("tdo_en low after exit", 32'(tdo_en), 32'd0);
    tck(1'b0, 1'b0);
    chk("back in RTI", 32'(tap_state), 32'd1);

    // Table of IR + DR scans.
    for (int v = 0; v < 7; v++) begin
      bsr_pin_in = vecs[v].pin_in;
      user_cap   = vecs[v].ucap;
      scan_ir(vecs[v].ir, ir_out);
      chk($sformatf("v%0d ir capture", v), 32'(ir_out), 32'd1);
      chk($sformatf("v%0d ir_q", v), 32'(ir_q), 32'(vecs[v].ir));
      chk($sformatf("v%0d bsr_extest", v), 32'(bsr_extest), 32'(vecs[v].exp_extest));
      scan_dr(vecs[v].dr_in, vecs[v].n, dr_out);
      chk($sformatf("v%0d dr tdo", v), dr_out, vecs[v].exp_out);
      chk($sformatf("v%0d bsr_pin_out", v), 32'(bsr_pin_out), 32'(vecs[v].exp_pin));
      chk($sformatf("v%0d user_q", v), 32'(user_q), 32'(vecs[v].exp_uq));
    end

    // USER scan with a pause in the middle.
    scan_ir(4'h3, ir_out);
    user_cap = 16'h1234;
    dr_out   = 32'h0;
    idv      = 32'h0000_BEEF;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tck(i == 7, idv[i]);
      dr_out[i] = tdo;
    end
    tck(1'b0, 1'b0);
    chk("pause state", 32'(tap_state), 32'd6);
    chk("pause tdo_en", 32'(tdo_en), 32'd0);
    tck(1'b0, 1'b1);
    tck(1'b1, 1'b1);
    chk("exit2 state", 32'(tap_state), 32'd7);
    tck(1'b0, 1'b0);
    chk("resume shift state", 32'(tap_state), 32'd4);
    for (int i = 8; i < 16; i++) begin
      tck(i == 15, idv[i]);
      dr_out[i] = tdo;
    end
    tck(1'b1, 1'b0);
    chk("upd_dr state", 32'(tap_state), 32'd8);
    chk("user_upd before edge", 32'(user_upd), 32'd0);
    tck(1'b0, 1'b0);
    chk("user_upd pulse", 32'(user_upd), 32'd1);
    chk("user_q after pause scan", 32'(user_q), 32'h0000_BEEF);
    chk("user capture out", dr_out, 32'h0000_1234);
    tck(1'b0, 1'b0);
    chk("user_upd one cycle", 32'(user_upd), 32'd0);

    // Five tms=1 edges from Shift-DR reach TLR; TLR then forces IDCODE.
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    chk("in SH_DR", 32'(tap_state), 32'd4);
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    chk("five tms ones", 32'(tap_state), 32'd0);
    chk("ir_q held on TLR entry", 32'(ir_q), 32'd3);
    tck(1'b1, 1'b0);
    chk("TLR forces IDCODE", 32'(ir_q), 32'd1);

    // Mid-scan asynchronous reset under USER.
    tck(1'b0, 1'b0);
    scan_ir(4'h3, ir_out);
    chk("user ir before reset", 32'(ir_q), 32'd3);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tck(1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("midscan reset state", 32'(tap_state), 32'd0);
    chk("midscan reset ir_q", 32'(ir_q), 32'd1);
    chk("midscan reset user_q", 32'(user_q), 32'd0);
    chk("midscan reset bsr_pin_out", 32'(bsr_pin_out), 32'd0);
    chk("midscan reset tdo_en", 32'(tdo_en), 32'd0);
    chk("midscan reset tdo", 32'(tdo), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tck(1'b0, 1'b0);
    scan_dr(32'h0, 32, dr_out);
    chk("idcode after reset", dr_out, 32'h1000_0A5B);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
